// File: rtl/clk_switch_n.sv
// clk_switch_n: glitch-free N-way clock multiplexer with req/ack control.
// The controller in the clk_a domain drops every grant and waits for the
// synchronised enables to read all-low before it raises a new one. Each
// source gates itself on its own falling edge, so clk_out never carries a
// pulse shorter than the source's own phase.
module clk_switch_n #(
    parameter int NUM_CLK  = 4,
    parameter int SYNC_STG = 2,
    parameter int RST_SEL  = 0,
    parameter int SEL_W    = $clog2(NUM_CLK + 1)
) (
    input  logic               clk_a,
    input  logic               rst_n,
    input  logic [NUM_CLK-1:0] clk_src,
    input  logic               sw_req,
    input  logic [SEL_W-1:0]   sw_sel,
    output logic               sw_ack,
    output logic               busy,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               parked,
    output logic               clk_out
);

    // Any selection at or above NUM_CLK parks the output low.
    localparam logic [SEL_W-1:0] PARK_MIN = SEL_W'(NUM_CLK);
    // A reset selection too wide for SEL_W falls back to the first park code.
    localparam int               RST_FIT  = (RST_SEL < (1 << SEL_W)) ? RST_SEL : NUM_CLK;
    localparam logic [SEL_W-1:0] RST_VAL  = SEL_W'(RST_FIT);
    localparam logic             RST_PARK = (RST_SEL >= NUM_CLK);

    typedef enum logic [1:0] {
        IDLE,
        DROP,
        RAISE
    } state_t;

    state_t                            state;
    logic [SEL_W-1:0]                  tgt;
    logic                              auto_sel;
    logic [NUM_CLK-1:0]                grant;
    logic [NUM_CLK-1:0]                en;
    logic [NUM_CLK-1:0]                fb;
    logic [SYNC_STG-1:0][NUM_CLK-1:0]  fb_sync;

    function automatic logic [NUM_CLK-1:0] onehot(input logic [SEL_W-1:0] s);
        return (s < PARK_MIN) ? (NUM_CLK'(1) << s) : '0;
    endfunction

    for (genvar i = 0; i < NUM_CLK; i++) begin : g_chan
        logic [SYNC_STG-1:0] gsync;
        logic                en_q;

        // Carry grant[i] into this source's own clock domain
        always_ff @(posedge clk_src[i] or negedge rst_n) begin
            if (!rst_n) begin
                gsync <= '0;
            end else begin
                gsync <= {gsync[SYNC_STG-2:0], grant[i]};
            end
        end

        // Change the gate only while the source is low
        always_ff @(negedge clk_src[i] or negedge rst_n) begin
            if (!rst_n) begin
                en_q <= 1'b0;
            end else begin
                en_q <= gsync[SYNC_STG-1];
            end
        end

        assign en[i] = en_q;
    end

    // Return the enables to clk_a so the controller knows what is really on
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            fb_sync <= '0;
        end else begin
            fb_sync <= {fb_sync[SYNC_STG-2:0], en};
        end
    end

    assign fb      = fb_sync[SYNC_STG-1];
    assign clk_out = |(en & clk_src);

    // Controller: clear all grants, wait for silence, then raise the target.
    // RAISE re-drives grant[tgt] every cycle because the post-reset entry
    // into RAISE starts with grants cleared by reset.
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST_PARK ? DROP : RAISE;
            tgt      <= RST_VAL;
            cur_sel  <= RST_VAL;
            grant    <= '0;
            sw_ack   <= 1'b0;
            busy     <= 1'b1;
            parked   <= 1'b1;
            auto_sel <= 1'b1;
        end else begin
            sw_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sw_req) begin
                        if (sw_sel == cur_sel) begin
                            sw_ack <= 1'b1;
                        end else begin
                            tgt   <= sw_sel;
                            grant <= '0;
                            busy  <= 1'b1;
                            state <= DROP;
                        end
                    end
                end
                DROP: begin
                    grant <= '0;
                    if (fb == '0) begin
                        if (tgt >= PARK_MIN) begin
                            cur_sel  <= tgt;
                            parked   <= 1'b1;
                            sw_ack   <= ~auto_sel;
                            auto_sel <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            grant <= onehot(tgt);
                            state <= RAISE;
                        end
                    end
                end
                RAISE: begin
                    grant <= onehot(tgt);
                    if ((fb & onehot(tgt)) != '0) begin
                        cur_sel  <= tgt;
                        parked   <= 1'b0;
                        sw_ack   <= ~auto_sel;
                        auto_sel <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_switch_n.sv
// Bench for clk_switch_n: randomized switch requests checked against a
// rule-level model (selection, park flag, ack count) plus a clk_out pulse
// monitor that classifies every pulse by width and checks gaps and sources.
`timescale 1ns/100ps
module tb_clk_switch_n;

    localparam int NUM_CLK  = 4;
    localparam int SYNC_STG = 2;
    localparam int RST_SEL  = 2;
    localparam int SEL_W    = $clog2(NUM_CLK + 1);
    localparam int TA       = 20;
    localparam int HALF [NUM_CLK] = '{15, 12, 5, 7};
    localparam int WIN      = 40;

    logic               clk_a  = 1'b0;
    logic               rst_n  = 1'b0;
    logic               src0   = 1'b0;
    logic               src1   = 1'b0;
    logic               src2   = 1'b0;
    logic               src3   = 1'b0;
    logic [NUM_CLK-1:0] clk_src;
    logic               sw_req = 1'b0;
    logic [SEL_W-1:0]   sw_sel = '0;
    logic               sw_ack;
    logic               busy;
    logic [SEL_W-1:0]   cur_sel;
    logic               parked;
    logic               clk_out;

    clk_switch_n #(
        .NUM_CLK (NUM_CLK),
        .SYNC_STG(SYNC_STG),
        .RST_SEL (RST_SEL)
    ) dut (
        .clk_a  (clk_a),
        .rst_n  (rst_n),
        .clk_src(clk_src),
        .sw_req (sw_req),
        .sw_sel (sw_sel),
        .sw_ack (sw_ack),
        .busy   (busy),
        .cur_sel(cur_sel),
        .parked (parked),
        .clk_out(clk_out)
    );

    always #(TA/2) clk_a = ~clk_a;
    initial begin #1; forever #(HALF[0]) src0 = ~src0; end
    initial begin #2; forever #(HALF[1]) src1 = ~src1; end
    initial begin #3; forever #(HALF[2]) src2 = ~src2; end
    initial begin #4; forever #(HALF[3]) src3 = ~src3; end
    assign clk_src = {src3, src2, src1, src0};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model state and monitor bookkeeping
    int                 cur_m     = RST_SEL;
    int                 exp_acks  = 0;
    int                 rst_epoch = 0;
    logic [NUM_CLK-1:0] allowed   = '0;

    time t_rise      = 0;
    time t_first     = 0;
    int  first_epoch = -1;
    time last_fall   = 0;
    int  last_src    = -1;
    int  last_epoch  = -1;
    int  pulse_cnt [NUM_CLK] = '{0, 0, 0, 0};
    int  bad_width    = 0;
    int  bad_src      = 0;
    int  bad_gap      = 0;
    int  ack_cnt      = 0;
    int  cur_unstable = 0;
    logic             prev_busy = 1'b1;
    logic [SEL_W-1:0] prev_cur  = '0;

    function automatic logic [NUM_CLK-1:0] mask(input int sel);
        return (sel < NUM_CLK) ? (NUM_CLK'(1) << sel) : '0;
    endfunction

    // Note every rising edge of clk_out, and the first one after each reset release
    always @(posedge clk_out) begin
        t_rise = $time;
        if (rst_n && first_epoch != rst_epoch) begin
            first_epoch = rst_epoch;
            t_first     = $time;
        end
    end

    // Classify each finished pulse by width; check source legality and low gaps
    always @(negedge clk_out) begin
        longint w;
        int     k;
        if (rst_n) begin
            w = longint'($time - t_rise);
            k = -1;
            for (int i = 0; i < NUM_CLK; i++) if (w == longint'(HALF[i])) k = i;
            if (k < 0) begin
                bad_width++;
            end else begin
                pulse_cnt[k]++;
                if (!allowed[k]) bad_src++;
                if (last_epoch == rst_epoch && last_src >= 0) begin
                    if (last_src == k) begin
                        if ((t_rise - last_fall) < time'(HALF[k])) bad_gap++;
                    end else begin
                        if ((t_rise - last_fall) < time'(SYNC_STG * TA)) bad_gap++;
                    end
                end
                last_src   = k;
                last_fall  = $time;
                last_epoch = rst_epoch;
            end
        end
    end

    // Count acks and watch cur_sel while a switch is in flight
    always @(negedge clk_a) begin
        if (sw_ack) ack_cnt++;
        if (rst_n && busy && prev_busy && cur_sel != prev_cur) cur_unstable++;
        prev_busy = busy;
        prev_cur  = cur_sel;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    // Hold reset, check reset values, release and check the automatic selection
    task automatic reset_phase();
        time t_rel;
        rst_n   = 1'b0;
        allowed = mask(RST_SEL);
        repeat (3) tick();
        chk("rst_busy",    int'(busy),    1);
        chk("rst_parked",  int'(parked),  1);
        chk("rst_cur_sel", int'(cur_sel), RST_SEL);
        chk("rst_ack",     int'(sw_ack),  0);
        chk("rst_clk_out", int'(clk_out), 0);
        rst_n = 1'b1;
        rst_epoch++;
        t_rel = $time;
        for (int c = 0; c < 200 && busy; c++) tick();
        chk("boot_done",    int'(busy),    0);
        chk("boot_cur_sel", int'(cur_sel), RST_SEL);
        chk("boot_parked",  int'(parked),  0);
        chk("boot_first_pulse", int'(first_epoch == rst_epoch &&
            (t_first - t_rel) <= time'(3 * 2 * HALF[RST_SEL] + 3 * TA)), 1);
        tick();
        chk("boot_no_ack", ack_cnt, exp_acks);
        cur_m = RST_SEL;
    endtask

    // Issue one request (called just after a clk_a edge); optionally spam while busy
    task automatic request(input int sel, input bit spam);
        bit got;
        sw_req = 1'b1;
        sw_sel = SEL_W'(sel);
        tick();
        sw_req = 1'b0;
        if (sel == cur_m) begin
            exp_acks++;
            chk("same_ack",     int'(sw_ack), 1);
            chk("same_busy",    int'(busy),   0);
            tick();
            chk("same_ack_end", int'(sw_ack), 0);
            chk("same_busy2",   int'(busy),   0);
            chk("same_cur_sel", int'(cur_sel), cur_m);
        end else begin
            allowed = mask(cur_m) | mask(sel);
            exp_acks++;
            chk("sw_busy_rise", int'(busy), 1);
            got = 1'b0;
            for (int c = 0; c < 400 && !got; c++) begin
                if (sw_ack) begin
                    got = 1'b1;
                end else begin
                    if (spam) begin
                        sw_req = 1'($urandom_range(0, 1));
                        sw_sel = SEL_W'($urandom_range(0, 7));
                    end
                    tick();
                end
            end
            sw_req = 1'b0;
            chk("sw_ack_seen", int'(got),     1);
            chk("sw_ack_busy", int'(busy),    0);
            chk("sw_cur_sel",  int'(cur_sel), sel);
            chk("sw_parked",   int'(parked),  int'(sel >= NUM_CLK));
            cur_m   = sel;
            allowed = mask(sel);
        end
    endtask

    // Let the selection run and confirm clk_out carries only the chosen source
    task automatic steady();
        int snap [NUM_CLK];
        for (int i = 0; i < NUM_CLK; i++) snap[i] = pulse_cnt[i];
        repeat (WIN) tick();
        chk("steady_busy", int'(busy), 0);
        chk("ack_total", ack_cnt, exp_acks);
        for (int i = 0; i < NUM_CLK; i++) begin
            if (i == cur_m) begin
                chk("follow_src", int'((pulse_cnt[i] - snap[i]) >=
                    (WIN * TA) / (2 * HALF[i]) - 2), 1);
            end else begin
                chk("silent_src", pulse_cnt[i] - snap[i], 0);
            end
        end
    endtask

    initial begin
        bit seen;
        int sel;

        reset_phase();
        steady();
        request(RST_SEL, 1'b0);
        steady();
        request(0, 1'b0);
        steady();
        request(4, 1'b0);
        steady();
        request(1, 1'b0);
        steady();
        request(3, 1'b1);
        steady();

        repeat (20) begin
            sel = ($urandom_range(0, 3) == 0) ? cur_m : int'($urandom_range(0, 6));
            request(sel, 1'($urandom_range(0, 1)));
            steady();
        end

        // Reset in the middle of RAISE, while a new-source pulse is high
        request(4, 1'b0);
        steady();
        sw_req = 1'b1;
        sw_sel = SEL_W'(1);
        tick();
        sw_req  = 1'b0;
        allowed = mask(1);
        chk("raise_busy", int'(busy), 1);
        seen = 1'b0;
        for (int c = 0; c < 8000 && !seen; c++) begin
            #1;
            seen = clk_out;
        end
        chk("raise_pulse_seen", int'(seen), 1);
        chk("raise_still_busy", int'(busy), 1);
        rst_n = 1'b0;
        #0.2;
        chk("rst_truncates", int'(clk_out), 0);
        reset_phase();
        steady();

        chk("bad_width",    bad_width,    0);
        chk("bad_src",      bad_src,      0);
        chk("bad_gap",      bad_gap,      0);
        chk("cur_unstable", cur_unstable, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_switch_n.md
# clk_switch_n

Parametrised, glitch-free N-way clock multiplexer with a request/acknowledge control interface. A controller in the clk_a domain selects one of NUM_CLK source clocks, or parks the output low. It never enables a new source until every previously enabled source is confirmed off, and each source is gated only on its own falling edge. It sits at the top of clock-generation subsystems wherever software or a power controller must retarget a functional clock at run time.

## Interface
- NUM_CLK, 4: number of source clocks; legal range 2..16.
- SYNC_STG, 2: synchroniser depth for each clock-domain crossing (grant into a source domain, feedback into clk_a); minimum 2.
- RST_SEL, 0: source enabled automatically after reset; a value ≥ NUM_CLK means stay parked after reset.
- SEL_W, derived as $clog2(NUM_CLK+1); do not override.
- clk_a  input  1  control clock; the FSM, handshake and status outputs run on it.
- rst_n  input  1  reset, asynchronous, active-low; clears flops in all domains.
- clk_src  input  NUM_CLK  source clocks, mutually asynchronous.
- sw_req  input  1  switch request, one clk_a cycle, sampled only in IDLE.
- sw_sel  input  SEL_W  target source; a value ≥ NUM_CLK means park.
- sw_ack  output  1  one-cycle pulse when a request completes.
- busy  output  1  high while a switch is in progress.
- cur_sel  output  SEL_W  currently committed selection.
- parked  output  1  high when no source is gated to the output.
- clk_out  output  1  muxed clock.

## Operation
- Per channel i, in the clk_src[i] domain:
  - grant[i] from the controller passes through SYNC_STG posedge flops.
  - A negedge flop then produces en[i].
  - clk_out = OR over i of (en[i] & clk_src[i]).
- en[i] is synchronised back to clk_a through SYNC_STG flops, giving fb[i].
- Controller FSM states: IDLE, DROP, RAISE.
  - IDLE: grant equals the one-hot of cur_sel, or all-zero when parked. On sw_req:
    - sw_sel == cur_sel: no state change; sw_ack pulses on the next cycle.
    - Otherwise: latch tgt = sw_sel, clear all grants, go to DROP.
  - DROP: hold grants at zero until fb == 0.
    - If tgt ≥ NUM_CLK: set cur_sel = tgt, parked = 1, pulse sw_ack, go to IDLE.
    - Else: set grant[tgt] = 1, go to RAISE.
  - RAISE: wait for fb[tgt] == 1. Then set cur_sel = tgt, parked = 0, pulse sw_ack, go to IDLE.
- busy = 1 in DROP and RAISE.
- sw_req while busy is ignored, with no queueing and no ack. The requester must wait for busy low.
- At most one en[i] is ever high. An en[i] can only rise after fb shows every channel low.
- Reset values: all grant, sync, en and fb flops = 0; clk_out = 0; sw_ack = 0; busy = 1; parked = 1; cur_sel = RST_SEL. The state is RAISE with tgt = RST_SEL, or DROP when RST_SEL ≥ NUM_CLK.
- The automatic post-reset selection completes without an sw_ack pulse and ends with busy = 0.
- Reset asserted mid-switch clears all enables immediately. A truncated high phase on clk_out is accepted at reset assertion only.
- A stopped source clock whose channel is enabled stalls DROP indefinitely. Recovery is by reset. There is no timeout in this generation.

## Timing
- Gating changes on clk_out happen only while the affected clk_src[i] is low. There are no pulses shorter than the source's own low or high phase.
- DROP latency: up to SYNC_STG+1 periods of the old source, plus SYNC_STG+1 clk_a cycles.
- RAISE latency: up to SYNC_STG+1 periods of the new source, plus SYNC_STG+1 clk_a cycles.
- Between the last old-source pulse and the first new-source pulse, clk_out is held low for at least SYNC_STG clk_a cycles.
- sw_ack coincides with the cycle busy falls and cur_sel updates. cur_sel is stable while busy.
- rst_n deassertion must be synchronised to clk_a by the integrator. Source-domain flops see grant = 0 at release, so no source-side synchroniser is needed.

## Test plan
- Reset release, NUM_CLK=4, RST_SEL=2 -> clk_out follows clk_src[2] after ≤ 3 src2 periods + 3 clk_a cycles; busy falls; sw_ack never pulses; cur_sel = 2; parked = 0.
- sw_req with sw_sel=0 (clk_src[2]=100 MHz, clk_src[0]=33 MHz, clk_a=50 MHz) -> no clk_out pulse narrower than 5 ns; a low gap of ≥ 2 clk_a cycles; one sw_ack; cur_sel = 0.
- sw_req with sw_sel = cur_sel -> sw_ack the next cycle; busy never rises; clk_out undisturbed.
- sw_req with sw_sel=4 (park), then sw_sel=1 -> clk_out held low with parked = 1; then clk_src[1] appears and parked = 0; two acks total.
- sw_req pulsed every cycle while busy -> only the first request takes effect; exactly one sw_ack.
- rst_n asserted during RAISE -> clk_out = 0 within the same cycle; after release, the RST_SEL sequence repeats.
